// File: rtl/cpu_multicycle_if.sv
// Instruction and data memory buses of cpu_multicycle; each side uses a req/ready handshake.
// The core drives the master modport, the memory system the slave modport.
interface cpu_multicycle_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [2:0]  dmem_op;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_op, dmem_addr, dmem_wdata,
        input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_op, dmem_addr, dmem_wdata,
        output imem_ready, imem_rdata, dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I/RV32E core: FETCH/EXEC/MEM/WB/HALT with stall-tolerant memory handshakes.
// Optional 64-bit cycle/instret counters behind macro CPU_MC_PERFCNT_EN.
module cpu_multicycle #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          REG_COUNT = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    cpu_multicycle_if.master      bus,
    output logic                  retire,
    output logic                  halted,
    input  logic [1:0]            dbgsel,
    output logic [31:0]           dbgdata
);
    localparam int   RIDX_W = $clog2(REG_COUNT);
    localparam logic E_MODE = (REG_COUNT == 16);

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                           OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;
    state_t r_state, w_next_state;

    logic [31:0] r_pc, r_ir, r_alu_q, r_rs2_q, r_next_pc_q, r_mdr;
    logic [31:0] r_regs [REG_COUNT];

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0:    alu = alt ? a - b : a + b;
            3'd1:    alu = a << b[4:0];
            3'd2:    alu = {31'd0, sa < sb};
            3'd3:    alu = {31'd0, a < b};
            3'd4:    alu = a ^ b;
            3'd5:    alu = alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6:    alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0:    branch_taken = (a == b);
            3'd1:    branch_taken = (a != b);
            3'd4:    branch_taken = (sa < sb);
            3'd5:    branch_taken = (sa >= sb);
            3'd6:    branch_taken = (a < b);
            3'd7:    branch_taken = (a >= b);
            default: branch_taken = 1'b0;
        endcase
    endfunction

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_rs1_val, w_rs2_val, w_pc4, w_result, w_next_pc;
    logic        w_reg_wr, w_use_rs1, w_use_rs2, w_known, w_is_load, w_is_store;
    logic        w_is_branch, w_is_jal, w_is_jalr, w_is_ebreak, w_taken, w_target_bad;
    logic        w_e_bad, w_halt, w_alt;

    assign w_opcode  = r_ir[6:0];
    assign w_rd      = r_ir[11:7];
    assign w_f3      = r_ir[14:12];
    assign w_rs1     = r_ir[19:15];
    assign w_rs2     = r_ir[24:20];
    assign w_imm_i   = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s   = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b   = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_u   = {r_ir[31:12], 12'd0};
    assign w_imm_j   = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1[RIDX_W-1:0]];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2[RIDX_W-1:0]];
    assign w_pc4     = r_pc + 32'd4;

    always_comb begin
        w_reg_wr = 1'b0; w_use_rs1 = 1'b0; w_use_rs2 = 1'b0; w_known = 1'b1;
        w_is_load = 1'b0; w_is_store = 1'b0; w_is_branch = 1'b0;
        w_is_jal = 1'b0; w_is_jalr = 1'b0; w_is_ebreak = 1'b0;
        case (w_opcode)
            OP_LUI, OP_AUIPC: w_reg_wr = 1'b1;
            OP_JAL:    begin w_reg_wr = 1'b1; w_is_jal = 1'b1; end
            OP_JALR:   begin w_reg_wr = 1'b1; w_use_rs1 = 1'b1; w_is_jalr = 1'b1; end
            OP_BRANCH: begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_is_branch = 1'b1; end
            OP_LOAD:   begin w_reg_wr = 1'b1; w_use_rs1 = 1'b1; w_is_load = 1'b1; end
            OP_STORE:  begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_is_store = 1'b1; end
            OP_IMM:    begin w_reg_wr = 1'b1; w_use_rs1 = 1'b1; end
            OP_REG:    begin w_reg_wr = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            OP_FENCE:  ;
            OP_SYSTEM: w_is_ebreak = (r_ir == 32'h0010_0073);
            default:   w_known = 1'b0;
        endcase
    end

    // Only funct7[5] of R-type selects sub/sra; for I-type it matters for shifts only
    assign w_alt   = (w_opcode == OP_REG) ? r_ir[30] : ((w_f3 == 3'd5) && r_ir[30]);
    assign w_taken = w_is_branch && branch_taken(w_f3, w_rs1_val, w_rs2_val);
    assign w_e_bad = E_MODE && ((w_use_rs1 && w_rs1[4]) || (w_use_rs2 && w_rs2[4]) ||
                                (w_reg_wr && w_rd[4]));

    always_comb begin
        case (w_opcode)
            OP_LUI:          w_result = w_imm_u;
            OP_AUIPC:        w_result = r_pc + w_imm_u;
            OP_JAL, OP_JALR: w_result = w_pc4;
            OP_LOAD:         w_result = w_rs1_val + w_imm_i;
            OP_STORE:        w_result = w_rs1_val + w_imm_s;
            OP_REG:          w_result = alu(w_f3, w_alt, w_rs1_val, w_rs2_val);
            default:         w_result = alu(w_f3, w_alt, w_rs1_val, w_imm_i);
        endcase
        if (w_is_jal)       w_next_pc = r_pc + w_imm_j;
        else if (w_is_jalr) w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
        else if (w_taken)   w_next_pc = r_pc + w_imm_b;
        else                w_next_pc = w_pc4;
    end

    assign w_target_bad = (w_is_jal || w_is_jalr || w_taken) && (w_next_pc[1:0] != 2'b00);
    assign w_halt       = !w_known || w_e_bad || w_is_ebreak || w_target_bad;

    always_ff @(posedge clock) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH: if (bus.imem_ready) w_next_state = EXEC;
            EXEC: begin
                if (w_halt)                        w_next_state = HALT;
                else if (w_is_load || w_is_store)  w_next_state = MEM;
                else                               w_next_state = WB;
            end
            MEM:   if (bus.dmem_ready) w_next_state = WB;
            WB:    w_next_state = FETCH;
            default: w_next_state = HALT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= RESET_PC;
            r_ir <= 32'd0;
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= 32'd0;
        end else begin
            if (r_state == FETCH && bus.imem_ready) r_ir <= bus.imem_rdata;
            if (r_state == WB) begin
                r_pc <= r_next_pc_q;
                if (w_reg_wr && w_rd != 5'd0)
                    r_regs[w_rd[RIDX_W-1:0]] <= w_is_load ? r_mdr : r_alu_q;
            end
        end
    end

    // Datapath latches carry no reset; they are always written before being consumed
    always_ff @(posedge clock) begin
        if (r_state == EXEC) begin
            r_alu_q     <= w_result;
            r_rs2_q     <= w_rs2_val;
            r_next_pc_q <= w_next_pc;
        end
        if (r_state == MEM && bus.dmem_ready && w_is_load) r_mdr <= bus.dmem_rdata;
    end

    assign bus.imem_req   = (r_state == FETCH);
    assign bus.imem_addr  = r_pc;
    assign bus.dmem_req   = (r_state == MEM);
    assign bus.dmem_we    = (r_state == MEM) && w_is_store;
    assign bus.dmem_op    = w_f3;
    assign bus.dmem_addr  = r_alu_q;
    assign bus.dmem_wdata = r_rs2_q;
    assign retire         = (r_state == WB);
    assign halted         = (r_state == HALT);

`ifdef CPU_MC_PERFCNT_EN
    logic [63:0] r_cycle, r_instret;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle   <= 64'd0;
            r_instret <= 64'd0;
        end else begin
            if (r_state != HALT) r_cycle   <= r_cycle + 64'd1;
            if (r_state == WB)   r_instret <= r_instret + 64'd1;
        end
    end

    always_comb begin
        case (dbgsel)
            2'd0:    dbgdata = r_pc;
            2'd1:    dbgdata = r_cycle[31:0];
            2'd2:    dbgdata = r_instret[31:0];
            default: dbgdata = r_ir;
        endcase
    end
`else
    always_comb begin
        case (dbgsel)
            2'd0:    dbgdata = r_pc;
            2'd3:    dbgdata = r_ir;
            default: dbgdata = 32'd0;
        endcase
    end
`endif
endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: ALU, stalls, branches, stores, halt paths, mid-transfer reset.
module tb_cpu_multicycle;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  dbgsel = 2'd0;
    logic        retire, halted, retire16, halted16;
    logic [31:0] dbgdata, dbgdata16;
    logic [31:0] imem [64];
    logic        iready = 1'b1;
    logic        dready = 1'b1;
    logic [31:0] dword = 32'd0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    cpu_multicycle_if bus ();
    cpu_multicycle_if bus16 ();

    assign bus.imem_ready   = iready;
    assign bus.imem_rdata   = imem[bus.imem_addr[7:2]];
    assign bus.dmem_ready   = dready;
    assign bus.dmem_rdata   = dword;
    assign bus16.imem_ready = 1'b1;
    assign bus16.imem_rdata = 32'h0010_0893;
    assign bus16.dmem_ready = 1'b1;
    assign bus16.dmem_rdata = 32'd0;

    cpu_multicycle #(.RESET_PC(32'h0), .REG_COUNT(32)) dut (
        .clock(clock), .reset(reset), .bus(bus.master), .retire(retire),
        .halted(halted), .dbgsel(dbgsel), .dbgdata(dbgdata));

    cpu_multicycle #(.RESET_PC(32'h0), .REG_COUNT(16)) dut16 (
        .clock(clock), .reset(reset), .bus(bus16.master), .retire(retire16),
        .halted(halted16), .dbgsel(2'd0), .dbgdata(dbgdata16));

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0010_0073;
    endtask

    task automatic start();
        reset = 1'b1; iready = 1'b1; dready = 1'b1; dbgsel = 2'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        cyc = 1;
    endtask

    task automatic dbg(input logic [1:0] sel, output logic [31:0] val);
        dbgsel = sel;
        #1;
        val = dbgdata;
        dbgsel = 2'd0;
        #1;
    endtask

    task automatic wait_dreq(input string tag);
        int n = 0;
        while (bus.dmem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, {31'd0, bus.dmem_req}, 32'd1);
    endtask

    logic [31:0] v;

    initial begin
        // ALU sequence and reset state
        clear_prog();
        imem[0] = 32'h0050_0093;
        imem[1] = 32'hFF90_8113;
        imem[2] = 32'h0020_81B3;
        start();
        check("rst_retire", {31'd0, retire}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_imem_req", {31'd0, bus.imem_req}, 32'd1);
        check("rst_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        check("rst_dmem_we", {31'd0, bus.dmem_we}, 32'd0);
        check("rst_imem_addr", bus.imem_addr, 32'h0);
        dbg(2'd3, v);
        check("rst_ir", v, 32'h0);
        for (int k = 1; k <= 9; k++) begin
            check($sformatf("t1_retire_c%0d", k), {31'd0, retire}, (k % 3 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        dbg(2'd0, v);
        check("t1_pc", v, 32'd12);
        check("t1_x3", dut.r_regs[3], 32'd3);
        check("t1_x2", dut.r_regs[2], 32'hFFFF_FFFE);
        dbg(2'd3, v);
        check("t1_ir", v, 32'h0020_81B3);
`ifdef CPU_MC_PERFCNT_EN
        dbg(2'd1, v);
        check("t1_cycle", v, 32'd9);
        dbg(2'd2, v);
        check("t1_instret", v, 32'd3);
`else
        dbg(2'd1, v);
        check("t1_dbg1_zero", v, 32'd0);
        dbg(2'd2, v);
        check("t1_dbg2_zero", v, 32'd0);
`endif

        // Fetch and load stalls
        clear_prog();
        imem[0] = 32'h0000_2283;
        dword = 32'hDEAD_BEEF;
        start();
        iready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("t2_ireq_c%0d", k), {31'd0, bus.imem_req}, 32'd1);
            check($sformatf("t2_iaddr_c%0d", k), bus.imem_addr, 32'h0);
            tick();
        end
        iready = 1'b1;
        tick();
        dready = 1'b0;
        tick();
        for (int k = 6; k <= 7; k++) begin
            check($sformatf("t2_dreq_c%0d", k), {31'd0, bus.dmem_req}, 32'd1);
            check($sformatf("t2_daddr_c%0d", k), bus.dmem_addr, 32'h0);
            check($sformatf("t2_dwe_c%0d", k), {31'd0, bus.dmem_we}, 32'd0);
            tick();
        end
        dready = 1'b1;
        check("t2_retire_c8", {31'd0, retire}, 32'd0);
        tick();
        check("t2_retire_c9", {31'd0, retire}, 32'd1);
        tick();
        check("t2_x5", dut.r_regs[5], 32'hDEAD_BEEF);

        // Branch and jump
        clear_prog();
        imem[0] = 32'h0000_0463;
        imem[1] = 32'h0000_1463;
        imem[2] = 32'hFFDF_F0EF;
        start();
        ticks(3);
        dbg(2'd0, v);
        check("t3_pc_beq", v, 32'd8);
        ticks(3);
        dbg(2'd0, v);
        check("t3_pc_jal", v, 32'd4);
        check("t3_x1", dut.r_regs[1], 32'd12);
        ticks(3);
        dbg(2'd0, v);
        check("t3_pc_bne", v, 32'd8);

        // Store widths
        clear_prog();
        imem[0] = 32'h1122_3337;
        imem[1] = 32'h3443_0313;
        imem[2] = 32'h1060_0023;
        imem[3] = 32'h1060_1023;
        imem[4] = 32'h1060_2023;
        start();
        for (int k = 0; k < 3; k++) begin
            wait_dreq($sformatf("t4_req%0d", k));
            check($sformatf("t4_op%0d", k), {29'd0, bus.dmem_op}, k);
            check($sformatf("t4_we%0d", k), {31'd0, bus.dmem_we}, 32'd1);
            check($sformatf("t4_wdata%0d", k), bus.dmem_wdata, 32'h1122_3344);
            check($sformatf("t4_addr%0d", k), bus.dmem_addr, 32'h100);
            tick();
        end
        check("t4_x6", dut.r_regs[6], 32'h1122_3344);

        // Halt on EBREAK; the RV32E instance halts on x17
        clear_prog();
        start();
        tick();
        check("t5a_halted_c2", {31'd0, halted}, 32'd0);
        tick();
        check("t5a_halted_c3", {31'd0, halted}, 32'd1);
        check("t5a_ireq_c3", {31'd0, bus.imem_req}, 32'd0);
        check("t5c_halted16", {31'd0, halted16}, 32'd1);
        check("t5c_x1_16", dut16.r_regs[1], 32'd0);
        ticks(4);
        check("t5a_halted_late", {31'd0, halted}, 32'd1);
        check("t5a_ireq_late", {31'd0, bus.imem_req}, 32'd0);
        check("t5a_retire_late", {31'd0, retire}, 32'd0);
        dbg(2'd0, v);
        check("t5a_pc", v, 32'd0);

        // Halt on opcode 0 after one retired instruction
        clear_prog();
        imem[0] = 32'h0050_0093;
        imem[1] = 32'h0000_0000;
        start();
        ticks(4);
        check("t5b_halted_c5", {31'd0, halted}, 32'd0);
        tick();
        check("t5b_halted_c6", {31'd0, halted}, 32'd1);
        check("t5b_ireq", {31'd0, bus.imem_req}, 32'd0);
        check("t5b_x1", dut.r_regs[1], 32'd5);
        dbg(2'd0, v);
        check("t5b_pc", v, 32'd4);

        // Reset during a stalled load
        clear_prog();
        imem[0] = 32'h0050_0093;
        imem[1] = 32'h0000_2283;
        start();
        dready = 1'b0;
        wait_dreq("t6_req");
        ticks(2);
        check("t6_req_held", {31'd0, bus.dmem_req}, 32'd1);
        check("t6_x1_before", dut.r_regs[1], 32'd5);
        reset = 1'b1;
        @(negedge clock);
        check("t6_dreq", {31'd0, bus.dmem_req}, 32'd0);
        check("t6_ireq", {31'd0, bus.imem_req}, 32'd1);
        check("t6_iaddr", bus.imem_addr, 32'h0);
        check("t6_x1", dut.r_regs[1], 32'd0);
        check("t6_retire", {31'd0, retire}, 32'd0);
        dbg(2'd1, v);
        check("t6_dbg1", v, 32'd0);
        reset = 1'b0;
        dready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
